// File: rtl/gpu_bg_pixel_writer.sv
// Purpose : executes the gwbg micro-op; shades one BG tile row (8 pixels, 2 bpp)
//           through the BG palette and writes the two packed bytes to the framebuffer.
// Latency : 11 cycles from iStart to oDone with iFbReady high; +1 per stalled write cycle.
// Backpressure: ready/valid write port; oFbWe/oFbAddr/oFbData hold while iFbReady=0.
//
// Ports:
//   iClock, iReset       clock, asynchronous active-low reset
//   iStart               one-cycle start strobe (ignored unless idle)
//   iBh, iBl, iBgp       tile row bit-planes and BG palette, latched on iStart
//   iFbAddrClear         synchronous clear of the write address (frame start)
//   iFbReady             framebuffer accepts the presented write this cycle
//   oFbWe/oFbAddr/oFbData framebuffer write port; oFbAddr doubles as fbuffer_addr
//   oBusy                high while an operation is in flight
//   oDone                one-cycle completion pulse
//   oFbWrap              one-cycle pulse after the address wraps to 0

module gpu_bg_pixel_writer #(
   parameter int FB_AW = 13
) (
   input  logic             iClock,
   input  logic             iReset,
   input  logic             iStart,
   input  logic [7:0]       iBh,
   input  logic [7:0]       iBl,
   input  logic [7:0]       iBgp,
   input  logic             iFbAddrClear,
   input  logic             iFbReady,
   output logic             oFbWe,
   output logic [FB_AW-1:0] oFbAddr,
   output logic [7:0]       oFbData,
   output logic             oBusy,
   output logic             oDone,
   output logic             oFbWrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHADE = 2'd1,
      WR0   = 2'd2,
      WR1   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [7:0]       bh_q, bh_d;
   logic [7:0]       bl_q, bl_d;
   logic [7:0]       bgp_q, bgp_d;
   logic [15:0]      pix_q, pix_d;
   logic [FB_AW-1:0] addr_q, addr_d;
   logic             we_q, we_d;
   logic [7:0]       data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wrap_q, wrap_d;

   logic             incr;
   logic [1:0]       idx;
   logic [1:0]       shade;
   logic [2:0]       bit_sel;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bh_d    = bh_q;
      bl_d    = bl_q;
      bgp_d   = bgp_q;
      pix_d   = pix_q;
      addr_d  = addr_q;
      we_d    = we_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      incr    = 1'b0;

      // Pixel i uses bit (7-i) of each plane; palette entry idx sits at bits 2*idx+1:2*idx.
      bit_sel = 3'd7 - cnt_q;
      idx     = {bh_q[bit_sel], bl_q[bit_sel]};
      shade   = bgp_q[{idx, 1'b0} +: 2];

      case (state_q)
         IDLE: begin
            if (iStart) begin
               bh_d    = iBh;
               bl_d    = iBl;
               bgp_d   = iBgp;
               cnt_d   = 3'd0;
               busy_d  = 1'b1;
               state_d = SHADE;
            end
         end
         SHADE: begin
            // Shift register: after 8 shifts pixel 0 lands in bits 15:14, pixel 7 in 1:0.
            pix_d = {pix_q[13:0], shade};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               // Present the high byte straight from the final word so WR0 is valid on entry.
               we_d    = 1'b1;
               data_d  = pix_d[15:8];
               state_d = WR0;
            end
         end
         WR0: begin
            if (iFbReady) begin
               incr    = 1'b1;
               data_d  = pix_q[7:0];
               state_d = WR1;
            end
         end
         WR1: begin
            if (iFbReady) begin
               incr    = 1'b1;
               we_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      // Frame-start clear beats a same-cycle increment; no wrap is reported in that case.
      if (iFbAddrClear) begin
         addr_d = '0;
      end else if (incr) begin
         addr_d = addr_q + {{(FB_AW-1){1'b0}}, 1'b1};
         wrap_d = &addr_q;
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         bh_q    <= 8'd0;
         bl_q    <= 8'd0;
         bgp_q   <= 8'd0;
         pix_q   <= 16'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         data_q  <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bh_q    <= bh_d;
         bl_q    <= bl_d;
         bgp_q   <= bgp_d;
         pix_q   <= pix_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   assign oFbWe   = we_q;
   assign oFbAddr = addr_q;
   assign oFbData = data_q;
   assign oBusy   = busy_q;
   assign oDone   = done_q;
   assign oFbWrap = wrap_q;

endmodule

// File: tb/tb_gpu_bg_pixel_writer.sv
// Purpose : scoreboard bench for gpu_bg_pixel_writer against a pixel-level reference model.
// Latency : checks strobe-to-done latency of 11 cycles plus stalled cycles.
// Backpressure: drives iFbReady low for chosen cycles and checks the write port holds.

module tb_gpu_bg_pixel_writer;

   localparam int FB_AW = 13;
   localparam int FB_SZ = 1 << FB_AW;

   logic             iClock;
   logic             iReset;
   logic             iStart;
   logic [7:0]       iBh, iBl, iBgp;
   logic             iFbAddrClear;
   logic             iFbReady;
   logic             oFbWe;
   logic [FB_AW-1:0] oFbAddr;
   logic [7:0]       oFbData;
   logic             oBusy, oDone, oFbWrap;

   gpu_bg_pixel_writer #(.FB_AW(FB_AW)) dut (
      .iClock       (iClock),
      .iReset       (iReset),
      .iStart       (iStart),
      .iBh          (iBh),
      .iBl          (iBl),
      .iBgp         (iBgp),
      .iFbAddrClear (iFbAddrClear),
      .iFbReady     (iFbReady),
      .oFbWe        (oFbWe),
      .oFbAddr      (oFbAddr),
      .oFbData      (oFbData),
      .oBusy        (oBusy),
      .oDone        (oDone),
      .oFbWrap      (oFbWrap)
   );

   initial iClock = 1'b0;
   always #5 iClock = ~iClock;

   int vectors    = 0;
   int miscompares = 0;

   int exp_addr_q[$];
   int exp_data_q[$];
   int addr_m = 0;      // model of the framebuffer write address

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Reference: shade each pixel from the palette and pack pixel 0 into the top bits.
   function automatic int model_word(input int bh, input int bl, input int bgp);
      int w;
      w = 0;
      for (int i = 0; i < 8; i++) begin
         int hi, lo, pal_idx, sh;
         hi      = (bh >> (7 - i)) & 1;
         lo      = (bl >> (7 - i)) & 1;
         pal_idx = 2 * hi + lo;
         sh      = (bgp >> (2 * pal_idx)) & 3;
         w       = w + (sh << (14 - 2 * i));
      end
      return w;
   endfunction

   // ---------------- monitor ----------------
   logic             prev_stall = 1'b0;
   logic [FB_AW-1:0] prev_addr  = '0;
   logic [7:0]       prev_data  = '0;
   logic             prev_acc_top = 1'b0;

   always @(negedge iClock) begin
      if (!iReset) begin
         prev_stall   <= 1'b0;
         prev_acc_top <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_we_hold",   int'(oFbWe),   1);
            chk("stall_addr_hold", int'(oFbAddr), int'(prev_addr));
            chk("stall_data_hold", int'(oFbData), int'(prev_data));
         end
         if (oFbWrap || prev_acc_top)
            chk("wrap_pulse_timing", int'(oFbWrap), int'(prev_acc_top));
         if (oFbWe && iFbReady) begin
            if (exp_addr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected at %0t",
                        oFbAddr, oFbData, $time);
            end else begin
               chk("write_addr", int'(oFbAddr), exp_addr_q.pop_front());
               chk("write_data", int'(oFbData), exp_data_q.pop_front());
            end
         end
         prev_stall   <= oFbWe && !iFbReady;
         prev_addr    <= oFbAddr;
         prev_data    <= oFbData;
         prev_acc_top <= oFbWe && iFbReady && (int'(oFbAddr) == FB_SZ - 1);
      end
   end

   // ---------------- driver ----------------
   // Called at posedge+1 with the DUT idle; returns at posedge+1 of the oDone cycle.
   task automatic run_op(input int bh, input int bl, input int bgp, input bit clr,
                         input int s0, input int s1, input bit poke);
      int w, cyc, writes, stalled0, stalled1, wraps, exp_wraps;
      w = model_word(bh, bl, bgp);
      if (clr) addr_m = 0;
      exp_wraps = ((addr_m + 2) >= FB_SZ) ? 1 : 0;
      exp_addr_q.push_back(addr_m % FB_SZ);
      exp_data_q.push_back((w >> 8) & 8'hFF);
      exp_addr_q.push_back((addr_m + 1) % FB_SZ);
      exp_data_q.push_back(w & 8'hFF);
      addr_m = (addr_m + 2) % FB_SZ;

      iBh = bh[7:0]; iBl = bl[7:0]; iBgp = bgp[7:0];
      iStart = 1'b1;
      @(posedge iClock); #1;
      iStart = 1'b0;
      iBh = 8'($urandom); iBl = 8'($urandom); iBgp = 8'($urandom);
      cyc = 1; writes = 0; stalled0 = 0; stalled1 = 0; wraps = 0;
      while (cyc < 80) begin
         if (oFbWrap) wraps++;
         if (oDone) break;
         chk("busy_in_op", int'(oBusy), 1);
         iFbAddrClear = (clr && cyc == 3);
         iStart       = (poke && cyc == 4);
         if (oFbWe) begin
            if (writes == 0 && stalled0 < s0) begin
               iFbReady = 1'b0; stalled0++;
            end else if (writes == 1 && stalled1 < s1) begin
               iFbReady = 1'b0; stalled1++;
            end else begin
               iFbReady = 1'b1; writes++;
            end
         end else begin
            iFbReady = 1'($urandom_range(0, 1));
         end
         @(posedge iClock); #1;
         cyc++;
      end
      iFbAddrClear = 1'b0;
      iStart       = 1'b0;
      if (!oDone) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: no oDone within %0d cycles", cyc);
      end else begin
         chk("done_latency", cyc, 11 + s0 + s1);
         chk("busy_at_done", int'(oBusy), 0);
         chk("addr_at_done", int'(oFbAddr), addr_m);
         chk("wrap_count",   wraps, exp_wraps);
      end
   endtask

   initial begin
      int n;
      iReset = 1'b0; iStart = 1'b0; iBh = '0; iBl = '0; iBgp = '0;
      iFbAddrClear = 1'b0; iFbReady = 1'b1;
      #12;
      chk("rst_we",   int'(oFbWe),   0);
      chk("rst_addr", int'(oFbAddr), 0);
      chk("rst_data", int'(oFbData), 0);
      chk("rst_busy", int'(oBusy),   0);
      chk("rst_done", int'(oDone),   0);
      chk("rst_wrap", int'(oFbWrap), 0);
      @(posedge iClock); #1;
      iReset = 1'b1;
      @(posedge iClock); #1;

      // identity palette, inverted palette, then backpressure 3/2
      run_op(8'hF0, 8'hCC, 8'hE4, 0, 0, 0, 0);
      run_op(8'hF0, 8'hCC, 8'h1B, 0, 0, 0, 0);
      run_op(8'hF0, 8'hCC, 8'hE4, 0, 3, 2, 0);

      // random ops until the address reaches 100, then clear + ignored start in SHADE
      while (addr_m != 100)
         run_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                0, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
      run_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             1, 0, 0, 1);

      // walk the address up to 8190 so the next op wraps
      n = (FB_SZ - 2 - addr_m) / 2;
      for (int k = 0; k < n; k++)
         run_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                0, ($urandom_range(0, 15) == 0) ? 1 : 0, 0, 0);
      chk("pre_wrap_addr", int'(oFbAddr), FB_SZ - 2);
      run_op(8'h5A, 8'h3C, 8'hD2, 0, 1, 1, 0);

      // reset in cycle 9 with the first write stalled
      iBh = 8'hAA; iBl = 8'h55; iBgp = 8'h9C; iFbReady = 1'b0; iStart = 1'b1;
      @(posedge iClock); #1;
      iStart = 1'b0;
      for (int c = 1; c < 9; c++) begin
         @(posedge iClock); #1;
      end
      chk("cycle9_we", int'(oFbWe), 1);
      iReset = 1'b0;
      #1;
      chk("midrst_we",   int'(oFbWe),   0);
      chk("midrst_busy", int'(oBusy),   0);
      chk("midrst_addr", int'(oFbAddr), 0);
      addr_m = 0;
      iFbReady = 1'b1;
      @(posedge iClock); #1;
      iReset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge iClock); #1;
      end
      chk("post_rst_busy", int'(oBusy), 0);

      // recovery from address 0
      run_op(8'hF0, 8'hCC, 8'hE4, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         @(posedge iClock); #1;
      end
      chk("queue_drained", exp_addr_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
